thumb_fetch_hw_buffer: RTL and testbench
========================================

Name: thumb_fetch_hw_buffer

Overview:
Upstream neighbour of the Thumb halfword-select decode stage. It issues word-aligned 32-bit instruction fetches and splits each returned word into two 16-bit halfwords. The halfwords are queued in order and presented one per cycle, each with its PC, to Thumb decode. It also handles branch redirects (flush), including odd-halfword targets (pc[1]=1) and discard of in-flight stale responses.

Parameters:
DEPTH_HW, 8, halfword queue depth; power of 2, >=4.
MAX_OUT, 2, maximum outstanding fetch requests, 1..3.

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  synchronous reset, active-high.
flush  in  1  redirect; discards queue and all outstanding fetches.
flush_pc  in  32  redirect target; bit0 ignored.
fetch_req  out  1  fetch request.
fetch_addr  out  32  word address; [1:0]=0.
fetch_gnt  in  1  request accepted this cycle (req&gnt).
rdata_valid  in  1  response valid; in order, at least 1 cycle after gnt.
rdata  in  32  response word; [15:0] = halfword at addr, [31:16] = halfword at addr+2.
hw_valid  out  1  halfword available.
hw_data  out  16  halfword.
hw_pc  out  32  halfword address; bit0=0.
hw_ready  in  1  consumer accepts (hw_valid&hw_ready).

Behaviour:
- States: IDLE, RUN.
  - Reset -> IDLE: fetch_req=0, hw_valid=0, queue empty, outstanding=0, discard=0, fetch_addr=0, hw_data=0, hw_pc=0.
  - Fetching starts only on the first flush (boot PC is delivered via flush). IDLE -> RUN on flush.
- flush (any state), next cycle:
  - queue empty.
  - fetch_addr = {flush_pc[31:2],2'b00}.
  - skip_lo = flush_pc[1].
  - discard += outstanding.
  - outstanding = 0.
- In the flush cycle, fetch_req and hw_valid are forced 0 combinationally; rdata_valid in that cycle counts as stale (decrements discard, not outstanding).
- Credit rule: fetch_req = RUN & ~flush & (outstanding+discard < MAX_OUT) & (free_hw >= 2*(outstanding+1)).
  - free_hw is queue free entries.
  - Guarantees every accepted response fits.
- On req&gnt: fetch_addr += 4 (wraps mod 2^32); outstanding += 1.
- On rdata_valid:
  - If discard>0: discard -= 1; data dropped.
  - Otherwise outstanding -= 1 and the word is enqueued:
    - both halves, low first, PCs addr and addr+2;
    - if skip_lo: high half only, then skip_lo is cleared.
- Queue accepts 2 writes and 1 read per cycle. Simultaneous enqueue+dequeue is legal at any occupancy the credit rule allows.
- Output is registered from the queue head. hw_valid = ~empty & ~flush. Zero-bubble: back-to-back halfwords every cycle while not empty.
- Latency: gnt to response N cycles; response to hw_valid = 1 cycle (write into queue, head visible next cycle).
- rdata_valid with outstanding=0 and discard=0 is a protocol error: ignored, counters unchanged.
- Reset mid-operation: everything returns to IDLE; in-flight responses after reset are ignored (counters 0).

Optional Feature:
Macro THUMB_FETCH_BUS_ERR_EN.
- Enabled:
  - adds input rerr (qualified with rdata_valid) and output hw_err;
  - each enqueued halfword carries rerr;
  - hw_err accompanies hw_data; reset 0.
- Disabled: ports absent; no error storage.

Decomposition:
- Package thumb_fetch_pkg: state enum {IDLE,RUN}; constants HW_W=16, WORD_W=32, PC_W=32; halfword-entry struct {data[15:0], pc[31:0], err}.
- Sub-module thumb_hw_fifo: 2-write/1-read circular queue, pointers of log2(DEPTH_HW)+1 bits; outputs count/free.
- Top holds the FSM, credit counters and address generation.

Test Plan:
- Reset then flush_pc=0x100, gnt=1, 1-cycle response 0xBBBBAAAA -> hw: 0xAAAA@0x100, 0xBBBB@0x102, continuous stream @0x104...
- Flush with flush_pc=0x202 -> fetch_addr=0x200; first hw = high half @0x202; no halfword @0x200 emitted.
- 2 requests outstanding, flush to 0x400, then 2 stale responses then 1 new -> stale dropped; first hw_pc=0x400.
- hw_ready=0 for 20 cycles -> queue fills to DEPTH_HW; fetch_req deasserts; no response lost or overwritten; resume in order.
- flush and rdata_valid in the same cycle, plus hw_valid&hw_ready pending -> hw_valid=0 that cycle; response dropped; discard accounting correct.
- fetch_addr=0xFFFFFFFC, then response -> hw_pc 0xFFFFFFFC, 0xFFFFFFFE; next fetch_addr=0x00000000.

Source files
------------

// File: rtl/thumb_fetch_hw_buffer_pkg.sv
// Shared types and constants for the Thumb fetch halfword buffer.
// The THUMB_FETCH_BUS_ERR_EN macro gives each halfword entry a live error bit.
package thumb_fetch_pkg;

  localparam int HW_W   = 16;
  localparam int WORD_W = 32;
  localparam int PC_W   = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [HW_W-1:0] data;
    logic [PC_W-1:0] pc;
    logic            err;
  } hw_entry_t;

  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] pc);
    return {pc[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/thumb_fetch_hw_buffer_if.sv
// Redirect, fetch bus, response and halfword output signals of the fetch buffer.
// THUMB_FETCH_BUS_ERR_EN adds rerr (with rdata_valid) and hw_err (with hw_data).
interface thumb_fetch_hw_buffer_if;
  import thumb_fetch_pkg::*;

  logic              flush;
  logic [PC_W-1:0]   flush_pc;
  logic              fetch_req;
  logic [PC_W-1:0]   fetch_addr;
  logic              fetch_gnt;
  logic              rdata_valid;
  logic [WORD_W-1:0] rdata;
  logic              hw_valid;
  logic [HW_W-1:0]   hw_data;
  logic [PC_W-1:0]   hw_pc;
  logic              hw_ready;
`ifdef THUMB_FETCH_BUS_ERR_EN
  logic              rerr;
  logic              hw_err;
`endif

  modport master (
    input  flush, flush_pc, fetch_gnt, rdata_valid, rdata, hw_ready,
`ifdef THUMB_FETCH_BUS_ERR_EN
    input  rerr,
    output hw_err,
`endif
    output fetch_req, fetch_addr, hw_valid, hw_data, hw_pc
  );

  modport slave (
    output flush, flush_pc, fetch_gnt, rdata_valid, rdata, hw_ready,
`ifdef THUMB_FETCH_BUS_ERR_EN
    output rerr,
    input  hw_err,
`endif
    input  fetch_req, fetch_addr, hw_valid, hw_data, hw_pc
  );

endinterface

// File: rtl/thumb_fetch_hw_buffer_fifo.sv
// Halfword queue: up to two writes and one read per cycle, head read straight from storage.
// Error bits are stored only when THUMB_FETCH_BUS_ERR_EN is defined.
module thumb_hw_fifo
  import thumb_fetch_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     wr_en_i,
  input  logic                     wr_two_i,
  input  hw_entry_t                wr0_i,
  input  hw_entry_t                wr1_i,
  input  logic                     rd_en_i,
  output hw_entry_t                head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [$clog2(DEPTH):0]   free_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0] PTR_TWO = (AW+1)'(2);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [HW_W-1:0]  data_q [DEPTH];
  logic [PC_W-1:0]  pc_q   [DEPTH];
  logic [AW-1:0]    wr_idx0_s, wr_idx1_s, rd_idx_s;

  assign wr_idx0_s = wr_ptr_q[AW-1:0];
  assign wr_idx1_s = wr_idx0_s + AW'(1);
  assign rd_idx_s  = rd_ptr_q[AW-1:0];

  // Extra pointer bit distinguishes full from empty.
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign free_o  = (AW+1)'(DEPTH) - count_o;

`ifdef THUMB_FETCH_BUS_ERR_EN
  logic err_q [DEPTH];
  assign head_o = '{data: data_q[rd_idx_s], pc: pc_q[rd_idx_s], err: err_q[rd_idx_s]};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) err_q[i] <= 1'b0;
    end else if (wr_en_i && !clr_i) begin
      err_q[wr_idx0_s] <= wr0_i.err;
      if (wr_two_i) err_q[wr_idx1_s] <= wr1_i.err;
    end
  end
`else
  logic unused_err_s;
  assign unused_err_s = wr0_i.err ^ wr1_i.err;
  assign head_o = '{data: data_q[rd_idx_s], pc: pc_q[rd_idx_s], err: 1'b0};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en_i) begin
        data_q[wr_idx0_s] <= wr0_i.data;
        pc_q[wr_idx0_s]   <= wr0_i.pc;
        if (wr_two_i) begin
          data_q[wr_idx1_s] <= wr1_i.data;
          pc_q[wr_idx1_s]   <= wr1_i.pc;
        end
        wr_ptr_q <= wr_ptr_q + (wr_two_i ? PTR_TWO : PTR_ONE);
      end
      if (rd_en_i) rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

endmodule

// File: rtl/thumb_fetch_hw_buffer.sv
// Word fetcher feeding Thumb decode: splits responses into PC-tagged halfwords, handles redirects.
// Optional THUMB_FETCH_BUS_ERR_EN carries the bus error of each word onto its halfwords.
module thumb_fetch_hw_buffer
  import thumb_fetch_pkg::*;
#(
  parameter int DEPTH_HW = 8,
  parameter int MAX_OUT  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  thumb_fetch_hw_buffer_if.master   bus
);

  localparam int         CW        = $clog2(DEPTH_HW) + 1;
  localparam logic [2:0] MAX_OUT_C = 3'(MAX_OUT);

  state_t          state_q, state_d;
  logic [1:0]      out_q, out_d, disc_q, disc_d;
  logic [PC_W-1:0] addr_q, addr_d, resp_q, resp_d;
  logic            skip_q, skip_d;

  logic [CW-1:0]   fifo_count_s, fifo_free_s;
  hw_entry_t       head_s, wr0_s, wr1_s;
  logic            wr_en_s, wr_two_s, rd_en_s;
  logic            hw_valid_s, req_s, gnt_s, acc_s, drop_s, rerr_s, credit_s;
  logic [2:0]      inflight_s;
  logic [1:0]      pend_sum_s;

`ifdef THUMB_FETCH_BUS_ERR_EN
  assign rerr_s     = bus.rerr;
  assign bus.hw_err = head_s.err;
`else
  logic unused_head_err_s;
  assign rerr_s            = 1'b0;
  assign unused_head_err_s = head_s.err;
`endif

  // A request is only issued when its whole response is guaranteed queue space.
  assign inflight_s = {1'b0, out_q} + {1'b0, disc_q};
  assign credit_s   = int'(fifo_free_s) >= 2 * (int'(out_q) + 1);
  assign req_s      = (state_q == RUN) && !bus.flush && (inflight_s < MAX_OUT_C) && credit_s;
  assign gnt_s      = req_s && bus.fetch_gnt;
  assign drop_s     = bus.rdata_valid && !bus.flush && (disc_q != 2'd0);
  assign acc_s      = bus.rdata_valid && !bus.flush && (disc_q == 2'd0) && (out_q != 2'd0);
  assign pend_sum_s = out_q + disc_q;

  assign hw_valid_s = (fifo_count_s != '0) && !bus.flush;
  assign rd_en_s    = hw_valid_s && bus.hw_ready;

  assign bus.fetch_req  = req_s;
  assign bus.fetch_addr = addr_q;
  assign bus.hw_valid   = hw_valid_s;
  assign bus.hw_data    = head_s.data;
  assign bus.hw_pc      = head_s.pc;

  thumb_hw_fifo #(.DEPTH(DEPTH_HW)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (bus.flush),
    .wr_en_i  (wr_en_s),
    .wr_two_i (wr_two_s),
    .wr0_i    (wr0_s),
    .wr1_i    (wr1_s),
    .rd_en_i  (rd_en_s),
    .head_o   (head_s),
    .count_o  (fifo_count_s),
    .free_o   (fifo_free_s)
  );

  // Next state: the boot PC arrives as the first redirect.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.flush) state_d = RUN; else state_d = IDLE;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Counters, address generation and queue write formation.
  always_comb begin
    addr_d   = addr_q;
    resp_d   = resp_q;
    skip_d   = skip_q;
    out_d    = out_q;
    disc_d   = disc_q;
    wr_en_s  = 1'b0;
    wr_two_s = 1'b0;
    wr0_s    = '0;
    wr1_s    = '0;
    if (bus.flush) begin
      // Everything in flight becomes stale; a response this cycle is already one of them.
      addr_d = word_align(bus.flush_pc);
      resp_d = word_align(bus.flush_pc);
      skip_d = bus.flush_pc[1];
      out_d  = 2'd0;
      disc_d = pend_sum_s - ((bus.rdata_valid && (pend_sum_s != 2'd0)) ? 2'd1 : 2'd0);
    end else begin
      if (gnt_s) addr_d = addr_q + 32'd4; else addr_d = addr_q;
      out_d = out_q + {1'b0, gnt_s} - {1'b0, acc_s};
      if (drop_s) disc_d = disc_q - 2'd1; else disc_d = disc_q;
      if (acc_s) begin
        wr_en_s = 1'b1;
        resp_d  = resp_q + 32'd4;
        skip_d  = 1'b0;
        if (skip_q) begin
          wr_two_s = 1'b0;
          wr0_s    = '{data: bus.rdata[31:16], pc: resp_q + 32'd2, err: rerr_s};
        end else begin
          wr_two_s = 1'b1;
          wr0_s    = '{data: bus.rdata[15:0],  pc: resp_q,          err: rerr_s};
          wr1_s    = '{data: bus.rdata[31:16], pc: resp_q + 32'd2, err: rerr_s};
        end
      end else begin
        wr_en_s = 1'b0;
      end
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      out_q   <= 2'd0;
      disc_q  <= 2'd0;
      addr_q  <= '0;
      resp_q  <= '0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      disc_q  <= disc_d;
      addr_q  <= addr_d;
      resp_q  <= resp_d;
      skip_q  <= skip_d;
    end
  end

endmodule

// File: tb/tb_thumb_fetch_hw_buffer.sv
// Self-checking bench: table of redirect scenarios plus hand-written corner sequences,
// with a scoreboard of expected halfwords fed from a model of the fetch responder.
module tb_thumb_fetch_hw_buffer;
  import thumb_fetch_pkg::*;

  localparam int DEPTH = 8;
  localparam int MAXO  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  thumb_fetch_hw_buffer_if bus();

  thumb_fetch_hw_buffer #(.DEPTH_HW(DEPTH), .MAX_OUT(MAXO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] data; logic [31:0] pc; logic err; } exp_t;
  typedef struct { logic [31:0] addr; int epoch; bit ghost; int due; } req_t;
  typedef struct {
    logic [31:0] fpc; int lat; int cycles;
    logic [31:0] faddr; logic [31:0] pc; logic [15:0] data;
  } vec_t;

  exp_t exp_q[$];
  req_t pend_q[$];
  vec_t vecs[5];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int epoch_m = 0;
  int lat = 1;
  int gnt_mode = 0;
  int ready_mode = 0;
  bit run_m = 0, skip_m = 0, first_seen = 0, do_flush = 0, flush_on_resp = 0;
  logic [31:0] fpc = 32'h0, exp_addr = 32'h0, first_pc = 32'h0;
  logic [15:0] first_data = 16'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [15:0] lo, hi;
    if (a == 32'h0000_0100) return 32'hBBBB_AAAA;
    lo = a[15:0] ^ 16'h5A5A;
    hi = (a[15:0] + 16'd2) ^ 16'h5A5A;
    return {hi, lo};
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return a[3] ^ a[5];
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_fetch_req"}, 32'(bus.fetch_req), 32'h0);
    chk({tag, "_hw_valid"}, 32'(bus.hw_valid), 32'h0);
    chk({tag, "_fetch_addr"}, bus.fetch_addr, 32'h0);
    chk({tag, "_hw_data"}, 32'(bus.hw_data), 32'h0);
    chk({tag, "_hw_pc"}, bus.hw_pc, 32'h0);
`ifdef THUMB_FETCH_BUS_ERR_EN
    chk({tag, "_hw_err"}, 32'(bus.hw_err), 32'h0);
`endif
  endtask

  // One clock cycle: drive at posedge+1, sample and update the model at the negedge.
  task automatic step();
    req_t r;
    exp_t e;
    bit resp_v, exp_req, stale;
    int n_live, n_out, l;
    logic [31:0] w;
    @(posedge clk); #1;
    cyc++;
    resp_v = 0; n_live = 0; n_out = 0;
    r = '{32'h0, 0, 1'b0, 0};
    foreach (pend_q[i]) if (!pend_q[i].ghost) begin
      n_live++;
      if (pend_q[i].epoch == epoch_m) n_out++;
    end
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      r = pend_q.pop_front();
      resp_v = 1;
    end
    if (flush_on_resp && resp_v && exp_q.size() > 0) begin
      do_flush = 1;
      flush_on_resp = 0;
    end
    exp_req = run_m && !do_flush && (n_live < MAXO) && ((DEPTH - exp_q.size()) >= 2 * (n_out + 1));
    w = mem_word(r.addr);
    bus.flush       = do_flush;
    bus.flush_pc    = fpc;
    bus.fetch_gnt   = (gnt_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    bus.hw_ready    = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    bus.rdata_valid = resp_v;
    bus.rdata       = resp_v ? w : $urandom();
`ifdef THUMB_FETCH_BUS_ERR_EN
    bus.rerr        = resp_v ? mem_err(r.addr) : 1'($urandom_range(0, 1));
`endif
    #4;
    chk("fetch_req", 32'(bus.fetch_req), 32'(exp_req));
    chk("hw_valid", 32'(bus.hw_valid), 32'(exp_q.size() != 0 && !do_flush));
    if (bus.hw_valid && bus.hw_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL hw_unexpected: got halfword at pc %h, expected none", bus.hw_pc);
      end else begin
        e = exp_q.pop_front();
        chk("hw_data", 32'(bus.hw_data), 32'(e.data));
        chk("hw_pc", bus.hw_pc, e.pc);
`ifdef THUMB_FETCH_BUS_ERR_EN
        chk("hw_err", 32'(bus.hw_err), 32'(e.err));
`endif
        if (!first_seen) begin
          first_seen = 1;
          first_pc   = bus.hw_pc;
          first_data = bus.hw_data;
        end
      end
    end
    if (bus.fetch_req && bus.fetch_gnt) begin
      chk("fetch_addr", bus.fetch_addr, exp_addr);
      l = (lat == 0) ? int'($urandom_range(1, 4)) : lat;
      pend_q.push_back('{exp_addr, epoch_m, 1'b0, cyc + l});
      exp_addr += 32'd4;
    end
    stale = r.ghost || do_flush || (r.epoch != epoch_m);
    if (resp_v && !stale) begin
      if (!skip_m) exp_q.push_back('{data: w[15:0], pc: r.addr, err: mem_err(r.addr)});
      exp_q.push_back('{data: w[31:16], pc: r.addr + 32'd2, err: mem_err(r.addr)});
      skip_m = 0;
    end
    if (do_flush) begin
      exp_q.delete();
      epoch_m++;
      skip_m     = fpc[1];
      exp_addr   = {fpc[31:2], 2'b00};
      run_m      = 1;
      first_seen = 0;
      do_flush   = 0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    cyc++;
    rst = 1'b1;
    bus.flush = 1'b0; bus.fetch_gnt = 1'b0; bus.rdata_valid = 1'b0; bus.hw_ready = 1'b0;
    @(posedge clk); #1;
    cyc++;
    rst = 1'b0;
    foreach (pend_q[i]) pend_q[i].ghost = 1'b1;
    exp_q.delete();
    epoch_m++;
    run_m = 0; skip_m = 0; first_seen = 0; exp_addr = 32'h0;
    #4;
    check_reset_vals("midrst");
  endtask

  task automatic flush_to(input logic [31:0] pc);
    fpc = pc;
    do_flush = 1;
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.flush = 1'b0; bus.flush_pc = 32'h0; bus.fetch_gnt = 1'b0;
    bus.rdata_valid = 1'b0; bus.rdata = 32'h0; bus.hw_ready = 1'b0;
`ifdef THUMB_FETCH_BUS_ERR_EN
    bus.rerr = 1'b0;
`endif
    vecs[0] = '{32'h0000_0100, 1, 12, 32'h0000_0100, 32'h0000_0100, 16'hAAAA};
    vecs[1] = '{32'h0000_0202, 1, 12, 32'h0000_0200, 32'h0000_0202, 16'h5858};
    vecs[2] = '{32'hFFFF_FFFC, 2, 12, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 16'hA5A6};
    vecs[3] = '{32'h0000_1237, 3, 14, 32'h0000_1234, 32'h0000_1236, 16'h486C};
    vecs[4] = '{32'h0000_0400, 4, 16, 32'h0000_0400, 32'h0000_0400, 16'h5E5A};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #4 check_reset_vals("boot");

    // No fetching until the first redirect.
    repeat (4) step();

    for (int i = 0; i < 5; i++) begin
      lat = vecs[i].lat;
      flush_to(vecs[i].fpc);
      step();
      chk("vec_fetch_addr", bus.fetch_addr, vecs[i].faddr);
      repeat (vecs[i].cycles) step();
      chk("vec_first_seen", 32'(first_seen), 32'h1);
      chk("vec_first_pc", first_pc, vecs[i].pc);
      chk("vec_first_data", 32'(first_data), 32'(vecs[i].data));
    end

    // Two requests in flight when redirecting: both responses must be dropped.
    lat = 5;
    flush_to(32'h0000_3000);
    repeat (3) step();
    lat = 1;
    flush_to(32'h0000_0400);
    repeat (20) step();
    chk("stale_first_pc", first_pc, 32'h0000_0400);
    chk("stale_first_data", 32'(first_data), 32'h0000_5E5A);

    // Consumer stalls: queue fills, requests stop, then drains in order.
    ready_mode = 1;
    repeat (20) step();
    chk("full_fetch_req", 32'(bus.fetch_req), 32'h0);
    ready_mode = 0;
    repeat (20) step();

    // Redirect in the same cycle as a response and a pending handshake.
    fpc = 32'h0000_0500;
    flush_on_resp = 1;
    for (int k = 0; k < 30 && flush_on_resp; k++) step();
    if (flush_on_resp) begin
      checks++; errors++;
      $display("FAIL coincident_flush: got no response cycle, expected one within 30 cycles");
      flush_on_resp = 0;
    end
    repeat (15) step();
    chk("coinc_first_pc", first_pc, 32'h0000_0500);
    chk("coinc_first_data", 32'(first_data), 32'h0000_5F5A);

    // Random grants, readiness, latency and redirects.
    gnt_mode = 1; ready_mode = 2; lat = 0;
    for (int k = 0; k < 300; k++) begin
      if (k % 70 == 35) begin
        fpc = {16'h0, 16'($urandom())};
        do_flush = 1;
      end
      step();
    end

    // Reset with fetches in flight: late responses must be ignored.
    gnt_mode = 0; ready_mode = 0; lat = 3;
    repeat (3) step();
    do_reset();
    for (int k = 0; k < 20 && pend_q.size() > 0; k++) step();
    if (pend_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL ghost_drain: got %0d responses pending, expected 0", pend_q.size());
      pend_q.delete();
    end
    chk("ghost_hw_data", 32'(bus.hw_data), 32'h0);
    chk("ghost_hw_pc", bus.hw_pc, 32'h0);
    chk("ghost_fetch_addr", bus.fetch_addr, 32'h0);
    lat = 1;
    flush_to(32'h0000_0600);
    repeat (12) step();
    chk("postrst_first_pc", first_pc, 32'h0000_0600);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
